store_access_controller_mem: RTL and testbench

MEM-stage sequencer that turns pipeline store requests into writes on the word-addressed data memory. Word stores go straight to memory. Byte and half-word stores are done as read-modify-write: read the containing word, merge the new lane, write it back. The block sits between the MEM pipeline register and the data RAM, and holds the pipeline through a request/acknowledge handshake until each store retires.

---
 rtl/mem_store_pkg.sv | 33 +++
 rtl/store_lane_merge.sv | 37 +++
 rtl/store_access_controller_mem.sv | 151 +++++++++++++++
 tb/tb_store_access_controller_mem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_store_pkg.sv
// Shared definitions for the MEM-stage store path.
// Size encodings are shared with the store/load sign-handling units. The
// package also holds the controller state encoding and the alignment helpers.
package mem_store_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWait  = 3'd2,
    StWrite = 3'd3,
    StErr   = 3'd4
  } ctrlState_e;

  // Byte and half stores need a read-modify-write; size 3 behaves as a word.
  function automatic logic isSubWord(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lane[0];
      default:   ok = (lane == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge for sub-word stores.
// Ports:
//   oldWord  - word read back from the data RAM
//   wrData   - store data; byte/half taken from the low bits, no sign extension
//   size     - store size encoding (word, byte, half; 3 acts as word)
//   laneAddr - byte address bits [1:0]
//   merged   - oldWord with the addressed lane replaced
module store_lane_merge
  import mem_store_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wrData,
  input  logic [1:0]  size,
  input  logic [1:0]  laneAddr,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    case (size)
      SIZE_BYTE: begin
        case (laneAddr)
          2'd0:    merged[7:0]   = wrData[7:0];
          2'd1:    merged[15:8]  = wrData[7:0];
          2'd2:    merged[23:16] = wrData[7:0];
          default: merged[31:24] = wrData[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (laneAddr[1]) merged[31:16] = wrData[15:0];
        else             merged[15:0]  = wrData[15:0];
      end
      default: merged = wrData;
    endcase
  end

endmodule

// File: rtl/store_access_controller_mem.sv
// MEM-stage store sequencer in front of the word-addressed data RAM.
// Word stores write directly; byte/half stores read the containing word,
// merge the new lane and write it back. The pipeline is held via stall until
// reqAck retires the request.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   reqValid/Size/Addr/Data - store request from the MEM pipeline register
//   reqAck, errMisalign   - one-cycle retire pulse, with error flag on rejection
//   stall                 - reqValid & ~reqAck
//   memAddr/Re/We/Wdata   - registered RAM command; memRdata is RAM read data
module store_access_controller_mem
  import mem_store_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  input  logic [1:0]        reqSize,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqData,
  output logic              reqAck,
  output logic              errMisalign,
  output logic              stall,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [31:0]       memWdata,
  input  logic [31:0]       memRdata
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LAT - 1);

  ctrlState_e        stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [1:0]        sizeQ, sizeD, laneQ, laneD;
  logic [31:0]       dataQ, dataD;

  logic [ADDR_W-1:0] memAddrD;
  logic              memReD, memWeD, reqAckD, errD;
  logic [31:0]       memWdataD;
  logic [31:0]       mergedWord;

  logic unusedAddrBits;
  assign unusedAddrBits = ^reqAddr[31:ADDR_W+2];

  assign stall = reqValid & ~reqAck;

  // Merge straight from the RAM port; the result is registered on the last
  // WAIT cycle, which is where the read word is captured.
  store_lane_merge uMerge (
    .oldWord  (memRdata),
    .wrData   (dataQ),
    .size     (sizeQ),
    .laneAddr (laneQ),
    .merged   (mergedWord)
  );

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    addrD     = addrQ;
    sizeD     = sizeQ;
    laneD     = laneQ;
    dataD     = dataQ;
    memAddrD  = '0;
    memReD    = 1'b0;
    memWeD    = 1'b0;
    memWdataD = '0;
    reqAckD   = 1'b0;
    errD      = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (reqValid) begin
          addrD = reqAddr[ADDR_W+1:2];
          sizeD = reqSize;
          laneD = reqAddr[1:0];
          dataD = reqData;
          if (!isAligned(reqSize, reqAddr[1:0])) begin
            stateD  = StErr;
            reqAckD = 1'b1;
            errD    = 1'b1;
          end else if (isSubWord(reqSize)) begin
            stateD   = StRead;
            memReD   = 1'b1;
            memAddrD = reqAddr[ADDR_W+1:2];
          end else begin
            stateD    = StWrite;
            memWeD    = 1'b1;
            memAddrD  = reqAddr[ADDR_W+1:2];
            memWdataD = reqData;
            reqAckD   = 1'b1;
          end
        end
      end
      StRead: begin
        stateD   = StWait;
        cntD     = '0;
        memAddrD = addrQ;
      end
      StWait: begin
        memAddrD = addrQ;
        if (cntQ == LastCnt) begin
          stateD    = StWrite;
          memWeD    = 1'b1;
          memWdataD = mergedWord;
          reqAckD   = 1'b1;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StWrite, StErr: stateD = StIdle;
      default:        stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ      <= StIdle;
      cntQ        <= '0;
      addrQ       <= '0;
      sizeQ       <= SIZE_WORD;
      laneQ       <= '0;
      dataQ       <= '0;
      memAddr     <= '0;
      memRe       <= 1'b0;
      memWe       <= 1'b0;
      memWdata    <= '0;
      reqAck      <= 1'b0;
      errMisalign <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      addrQ       <= addrD;
      sizeQ       <= sizeD;
      laneQ       <= laneD;
      dataQ       <= dataD;
      memAddr     <= memAddrD;
      memRe       <= memReD;
      memWe       <= memWeD;
      memWdata    <= memWdataD;
      reqAck      <= reqAckD;
      errMisalign <= errD;
    end
  end

endmodule

// File: tb/tb_store_access_controller_mem.sv
// Directed bench: one controller with MEM_LAT=1, one with MEM_LAT=3, each with
// its own RAM model, plus a standalone lane-merge instance.
module tb_store_access_controller_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, selLat3;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqData;

  logic        ack1, err1, stall1, re1, we1;
  logic [9:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic        ack3, err3, stall3, re3, we3;
  logic [9:0]  addr3;
  logic [31:0] wdata3, rdata3;

  logic        pre;
  logic [9:0]  preA;
  logic [31:0] preV;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  store_access_controller_mem #(.ADDR_W(10), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid & ~selLat3), .reqSize(reqSize),
    .reqAddr(reqAddr), .reqData(reqData), .reqAck(ack1), .errMisalign(err1),
    .stall(stall1), .memAddr(addr1), .memRe(re1), .memWe(we1), .memWdata(wdata1),
    .memRdata(rdata1)
  );

  store_access_controller_mem #(.ADDR_W(10), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid & selLat3), .reqSize(reqSize),
    .reqAddr(reqAddr), .reqData(reqData), .reqAck(ack3), .errMisalign(err3),
    .stall(stall3), .memAddr(addr3), .memRe(re3), .memWe(we3), .memWdata(wdata3),
    .memRdata(rdata3)
  );

  // RAM models; read data is garbage outside the valid cycle.
  logic [31:0] ram1 [0:1023];
  logic [31:0] ram3 [0:1023];
  logic [31:0] p1, p3a, p3b, p3c;
  logic        v1, v3a, v3b, v3c;

  always @(posedge clk) begin
    if (pre) begin
      ram1[preA] <= preV;
      ram3[preA] <= preV;
    end
    if (we1) ram1[addr1] <= wdata1;
    if (we3) ram3[addr3] <= wdata3;
    v1  <= re1;  p1  <= ram1[addr1];
    v3a <= re3;  p3a <= ram3[addr3];
    v3b <= v3a;  p3b <= p3a;
    v3c <= v3b;  p3c <= p3b;
  end
  assign rdata1 = v1  ? p1  : 32'hBAD0BAD0;
  assign rdata3 = v3c ? p3c : 32'hBAD0BAD0;

  logic        obsAck, obsErr, obsStall, obsRe, obsWe;
  logic [9:0]  obsAddr;
  logic [31:0] obsWdata;
  assign obsAck   = selLat3 ? ack3   : ack1;
  assign obsErr   = selLat3 ? err3   : err1;
  assign obsStall = selLat3 ? stall3 : stall1;
  assign obsRe    = selLat3 ? re3    : re1;
  assign obsWe    = selLat3 ? we3    : we1;
  assign obsAddr  = selLat3 ? addr3  : addr1;
  assign obsWdata = selLat3 ? wdata3 : wdata1;

  logic [31:0] mOld, mData, mOut;
  logic [1:0]  mSize, mLane;
  store_lane_merge uMerge (
    .oldWord(mOld), .wrData(mData), .size(mSize), .laneAddr(mLane), .merged(mOut)
  );

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    pre = 1'b1; preA = a; preV = v;
    @(negedge clk);
    pre = 1'b0;
  endtask

  // Issue one store at a negedge (cycle T) and record what happens at T+k.
  task automatic doStore(input string tag, input logic lat3, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input int expAck,
                         input int expRe, input int expWe, input logic [31:0] expAddr,
                         input logic [31:0] expWdata, input logic expErr);
    int ackAt = 0, reAt = 0, weAt = 0, reCnt = 0, weCnt = 0;
    logic [31:0] wd = '0, wa = '0, ra = '0;
    logic errSeen = 1'b0, stallOk;
    selLat3 = lat3; reqSize = sz; reqAddr = a; reqData = d; reqValid = 1'b1;
    #1;
    stallOk = (obsStall === 1'b1);
    for (int k = 1; k <= 10 && ackAt == 0; k++) begin
      @(negedge clk);
      if (obsRe) begin reCnt++; reAt = k; ra = 32'(obsAddr); end
      if (obsWe) begin weCnt++; weAt = k; wa = 32'(obsAddr); wd = obsWdata; end
      if (obsAck) begin
        ackAt = k; errSeen = obsErr;
        if (obsStall !== 1'b0) stallOk = 1'b0;
        reqValid = 1'b0;
      end else if (obsStall !== 1'b1) begin
        stallOk = 1'b0;
      end
    end
    reqValid = 1'b0;
    checkEq({tag, " ackCycle"}, ackAt, expAck);
    checkEq({tag, " err"}, 32'(errSeen), 32'(expErr));
    checkEq({tag, " reCount"}, reCnt, (expRe != 0) ? 1 : 0);
    checkEq({tag, " reCycle"}, reAt, expRe);
    checkEq({tag, " reAddr"}, ra, (expRe != 0) ? expAddr : 32'h0);
    checkEq({tag, " weCount"}, weCnt, (expWe != 0) ? 1 : 0);
    checkEq({tag, " weCycle"}, weAt, expWe);
    checkEq({tag, " weAddr"}, wa, (expWe != 0) ? expAddr : 32'h0);
    checkEq({tag, " wdata"}, wd, expWdata);
    checkEq({tag, " stall"}, 32'(stallOk), 32'h1);
    @(negedge clk);
    checkEq({tag, " idleOut"}, {obsAck, obsErr, obsRe, obsWe, obsAddr, obsWdata != 0}, '0);
  endtask

  initial begin
    logic weSeen;
    rst_n = 1'b0; reqValid = 1'b0; selLat3 = 1'b0; reqSize = 2'd0;
    reqAddr = '0; reqData = '0; pre = 1'b0; preA = '0; preV = '0;
    mOld = '0; mData = '0; mSize = '0; mLane = '0;
    repeat (3) @(negedge clk);

    checkEq("rst1 outs", {ack1, err1, re1, we1, addr1, stall1}, '0);
    checkEq("rst1 wdata", wdata1, 32'h0);
    checkEq("rst3 outs", {ack3, err3, re3, we3, addr3, stall3}, '0);
    checkEq("rst3 wdata", wdata3, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    doStore("word", 1'b0, 2'd0, 32'h40, 32'hDEADBEEF, 1, 0, 1, 32'h10, 32'hDEADBEEF, 1'b0);
    preload(10'h10, 32'hAABBCCDD);
    doStore("byte1", 1'b0, 2'd1, 32'h41, 32'h00000011, 3, 1, 3, 32'h10, 32'hAABB11DD, 1'b0);
    preload(10'h10, 32'hAABBCCDD);
    doStore("half2", 1'b0, 2'd2, 32'h42, 32'hFFFF1234, 3, 1, 3, 32'h10, 32'h1234CCDD, 1'b0);
    preload(10'h10, 32'hAABBCCDD);
    doStore("byte3", 1'b0, 2'd1, 32'h43, 32'hFFFFFF77, 3, 1, 3, 32'h10, 32'h77BBCCDD, 1'b0);
    preload(10'h10, 32'hAABBCCDD);
    doStore("half0", 1'b0, 2'd2, 32'h40, 32'hABCD5678, 3, 1, 3, 32'h10, 32'hAABB5678, 1'b0);
    doStore("misHalf", 1'b0, 2'd2, 32'h43, 32'h12345678, 1, 0, 0, 32'h0, 32'h0, 1'b1);
    doStore("misWord", 1'b0, 2'd0, 32'h42, 32'h12345678, 1, 0, 0, 32'h0, 32'h0, 1'b1);
    doStore("size3", 1'b0, 2'd3, 32'h44, 32'hCAFEF00D, 1, 0, 1, 32'h11, 32'hCAFEF00D, 1'b0);
    preload(10'h10, 32'hAABBCCDD);
    doStore("lat3", 1'b1, 2'd1, 32'h40, 32'h00000099, 5, 1, 5, 32'h10, 32'hAABBCC99, 1'b0);

    // Reset while the MEM_LAT=1 controller sits in WAIT.
    preload(10'h10, 32'hAABBCCDD);
    selLat3 = 1'b0; reqSize = 2'd1; reqAddr = 32'h41; reqData = 32'h55; reqValid = 1'b1;
    @(negedge clk);
    checkEq("rstWait read", 32'(re1), 32'h1);
    weSeen = we1;
    @(negedge clk);
    weSeen = weSeen | we1;
    rst_n = 1'b0;
    @(negedge clk);
    weSeen = weSeen | we1;
    checkEq("rstWait outs", {ack1, err1, re1, we1, addr1}, '0);
    checkEq("rstWait wdata", wdata1, 32'h0);
    rst_n = 1'b1; reqValid = 1'b0;
    @(negedge clk);
    weSeen = weSeen | we1;
    checkEq("rstWait noWrite", 32'(weSeen), 32'h0);
    checkEq("rstWait ram", ram1[10'h10], 32'hAABBCCDD);
    doStore("postRst", 1'b0, 2'd0, 32'h48, 32'h0BADF00D, 1, 0, 1, 32'h12, 32'h0BADF00D, 1'b0);

    mOld = 32'hAABBCCDD; mData = 32'h11223344;
    mSize = 2'd1; mLane = 2'd0; #1; checkEq("merge b0", mOut, 32'hAABBCC44);
    mSize = 2'd1; mLane = 2'd2; #1; checkEq("merge b2", mOut, 32'hAA44CCDD);
    mSize = 2'd2; mLane = 2'd0; #1; checkEq("merge h0", mOut, 32'hAABB3344);
    mSize = 2'd2; mLane = 2'd2; #1; checkEq("merge h2", mOut, 32'h3344CCDD);
    mSize = 2'd0; mLane = 2'd0; #1; checkEq("merge w", mOut, 32'h11223344);
    mSize = 2'd3; mLane = 2'd0; #1; checkEq("merge s3", mOut, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
